// File: rtl/dmem_bytelane_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and dmem_bytelane_ctrl (slave).
interface dmem_bytelane_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bytelane_ctrl.sv
// Word-organised data memory with byte/half/word access, extension, error checks and LAT wait cycles.
// Define DMEM_ACCESS_CNT_EN to add saturating load/store/error access counters.
module dmem_bytelane_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LAT         = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_bytelane_ctrl_if.slave bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]         rd_count_o,
  output logic [15:0]         wr_count_o,
  output logic [7:0]          err_count_o
`endif
);
  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_in, acc;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept, enter_resp, acc_err;
  logic [ADDR_W-3:0] acc_idx;
  logic [IDX_W-1:0]  word_sel;
  logic [1:0]        lane;
  logic [31:0]       rd_word, load_data, wr_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [3:0]        wr_be;

  always_comb begin
    req_in.we    = bus.req_we;
    req_in.size  = bus.req_size;
    req_in.uns   = bus.req_unsigned;
    req_in.addr  = bus.req_addr;
    req_in.wdata = bus.req_wdata;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        if (LAT == 0) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_RESP;
               else               cnt_d   = cnt_q - 4'd1;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With LAT=0 the access happens on the accept edge itself, before req_q holds the request.
  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign acc        = (state_q == ST_IDLE) ? req_in : req_q;
  assign acc_idx    = acc.addr[ADDR_W-1:2];
  assign word_sel   = acc_idx[IDX_W-1:0];
  assign lane       = acc.addr[1:0];
  assign rd_word    = mem_q[word_sel];

  assign acc_err = (acc.size == 2'b11)
                || (acc.size == 2'b01 && acc.addr[0])
                || (acc.size == 2'b10 && acc.addr[1:0] != 2'b00)
                || (64'(acc_idx) >= 64'(DEPTH_WORDS));

  always_comb begin
    byte_v    = rd_word[8*lane +: 8];
    half_v    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    unique case (acc.size)
      2'b00:   load_data = {{24{byte_v[7] & ~acc.uns}}, byte_v};
      2'b01:   load_data = {{16{half_v[15] & ~acc.uns}}, half_v};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = acc.wdata;
    unique case (acc.size)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{acc.wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // NOTE: the storage array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && acc.we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[word_sel][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      req_q        <= '0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= req_in;
      if (enter_resp) begin
        resp_err_q   <= acc_err;
        resp_rdata_q <= (acc_err || acc.we) ? 32'd0 : load_data;
      end
    end
  end

  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= 16'd0;
      wr_cnt_q  <= 16'd0;
      err_cnt_q <= 8'd0;
    end else if (enter_resp) begin
      if (acc_err) begin
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end else if (acc.we) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;
  assign err_count_o = err_cnt_q;
`endif
endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Self-checking bench for dmem_bytelane_ctrl: directed scenarios plus random traffic against a byte-array model.
// Build with DMEM_ACCESS_CNT_EN defined to also exercise the access counters.
module tb_dmem_bytelane_ctrl;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int LAT    = 1;
  localparam int MAXW   = LAT + 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_bytelane_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_count, wr_count;
  logic [7:0]  err_count;
`endif

  dmem_bytelane_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count_o  (rd_count),
    .wr_count_o  (wr_count),
    .err_count_o (err_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory as a flat little-endian byte array.
  logic [7:0]  ref_mem [4*DEPTH];
  logic [31:0] exp_rd;
  logic        exp_err;

  logic [31:0] obs_rd, obs_post_rdata;
  logic        obs_err, obs_seen, obs_post_valid, obs_post_ready;
  int          obs_lat, obs_busy;

  task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd);
    int nb;
    longint val;
    nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_err = (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= DEPTH);
    exp_rd  = 32'd0;
    if (!exp_err) begin
      if (we) begin
        for (int k = 0; k < nb; k++) ref_mem[a + k] = wd[8*k +: 8];
      end else begin
        val = 0;
        for (int k = 0; k < nb; k++) val += longint'(ref_mem[a + k]) << (8*k);
        if (!uns && nb < 4 && val >= (longint'(1) << (8*nb - 1))) val -= longint'(1) << (8*nb);
        exp_rd = val[31:0];
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full request: model update, drive, wait for accept, scramble req_* after accept, collect response.
  task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd);
    int n;
    model_access(we, sz, uns, a, wd);
    obs_seen = 1'b0; obs_lat = 0; obs_busy = 0; obs_rd = 32'd0; obs_err = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
    bus.req_addr = a; bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < MAXW) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'($urandom); bus.req_size = 2'($urandom); bus.req_unsigned = 1'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (!bus.req_ready) obs_busy++;
      if (bus.resp_valid) begin
        obs_seen = 1'b1; obs_lat = i + 1; obs_rd = bus.resp_rdata; obs_err = bus.resp_err;
        break;
      end
    end
    @(negedge clk);
    obs_post_valid = bus.resp_valid;
    obs_post_ready = bus.req_ready;
    obs_post_rdata = bus.resp_rdata;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %0b want 1", bus.req_ready); end
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset resp_valid: got %0b want 0", bus.resp_valid); end
    n_checks++;
    if (bus.resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset resp_rdata: got %h want 0", bus.resp_rdata); end
    n_checks++;
    if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset resp_err: got %0b want 0", bus.resp_err); end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic prime_memory();
    for (int w = 0; w < 32; w++) txn(1'b1, 2'd2, 1'b0, 32'(4*w), $urandom);
    txn(1'b1, 2'd2, 1'b0, 32'(4*DEPTH - 4), $urandom);
  endtask

  task automatic test_word_store_load();
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    if (obs_seen !== 1'b1 || obs_err !== 1'b0 || obs_rd !== 32'd0) begin
      n_fail++; $display("FAIL word_store resp: seen=%0b err=%0b rdata=%h want 1/0/0", obs_seen, obs_err, obs_rd);
    end
    n_checks++;
    if (obs_lat != LAT + 1) begin n_fail++; $display("FAIL word_store latency: got %0d want %0d", obs_lat, LAT + 1); end
    n_checks++;
    if (obs_busy != LAT + 1) begin n_fail++; $display("FAIL word_store ready_low: got %0d want %0d", obs_busy, LAT + 1); end
    n_checks++;
    if (obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin
      n_fail++; $display("FAIL word_store pulse: valid_after=%0b ready_after=%0b want 0/1", obs_post_valid, obs_post_ready);
    end
    n_checks++;
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    if (obs_rd !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL word_load: rdata=%h err=%0b want deadbeef/0", obs_rd, obs_err);
    end
    n_checks++;
    if (obs_lat != LAT + 1 || obs_busy != LAT + 1) begin
      n_fail++; $display("FAIL word_load timing: lat=%0d busy=%0d want %0d", obs_lat, obs_busy, LAT + 1);
    end
    n_checks++;
    if (obs_post_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold: got %h want deadbeef", obs_post_rdata); end
    n_checks++;
  endtask

  task automatic test_byte_lanes();
    logic [7:0]  bytes_v [4];
    logic [31:0] want [5];
    logic [1:0]  sz   [5];
    logic        uns  [5];
    logic [31:0] addr [5];
    bytes_v = '{8'h11, 8'h22, 8'h33, 8'h84};
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 2'd0, 1'b0, 32'(32'h20 + i), {24'hABCDEF, bytes_v[i]});
      if (obs_err !== 1'b0) begin n_fail++; $display("FAIL byte_store %0d err: got %0b want 0", i, obs_err); end
      n_checks++;
    end
    addr = '{32'h20, 32'h23, 32'h23, 32'h22, 32'h20};
    sz   = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
    uns  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    want = '{32'h84332211, 32'hFFFFFF84, 32'h00000084, 32'hFFFF8433, 32'h00002211};
    for (int i = 0; i < 5; i++) begin
      txn(1'b0, sz[i], uns[i], addr[i], 32'h0);
      if (obs_rd !== want[i] || obs_err !== 1'b0) begin
        n_fail++; $display("FAIL lane_load %0d: rdata=%h err=%0b want %h/0", i, obs_rd, obs_err, want[i]);
      end
      n_checks++;
    end
  endtask

  task automatic test_errors();
    txn(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF);
    if (obs_err !== 1'b1 || obs_rd !== 32'd0) begin
      n_fail++; $display("FAIL misaligned_half_store: err=%0b rdata=%h want 1/0", obs_err, obs_rd);
    end
    n_checks++;
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    if (obs_rd !== 32'h84332211) begin n_fail++; $display("FAIL word_after_err_store: got %h want 84332211", obs_rd); end
    n_checks++;
    txn(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    if (obs_err !== 1'b1 || obs_rd !== 32'd0) begin
      n_fail++; $display("FAIL misaligned_word_load: err=%0b rdata=%h want 1/0", obs_err, obs_rd);
    end
    n_checks++;
    txn(1'b0, 2'd0, 1'b1, 32'(4*DEPTH), 32'h0);
    if (obs_err !== 1'b1 || obs_rd !== 32'd0) begin
      n_fail++; $display("FAIL out_of_range_load: err=%0b rdata=%h want 1/0", obs_err, obs_rd);
    end
    n_checks++;
    txn(1'b0, 2'd2, 1'b0, 32'(4*DEPTH - 4), 32'h0);
    if (obs_err !== 1'b0 || obs_rd !== exp_rd) begin
      n_fail++; $display("FAIL last_word_load: err=%0b rdata=%h want 0/%h", obs_err, obs_rd, exp_rd);
    end
    n_checks++;
    txn(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    if (obs_err !== 1'b1 || obs_rd !== 32'd0) begin
      n_fail++; $display("FAIL reserved_size: err=%0b rdata=%h want 1/0", obs_err, obs_rd);
    end
    n_checks++;
    txn(1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'hCAFEF00D);
    txn(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL oor_store_alias: word0 got %h want %h", obs_rd, exp_rd); end
    n_checks++;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    logic saw_resp;
    if (LAT > 0) begin
      txn(1'b1, 2'd2, 1'b0, 32'h40, 32'hAAAAAAAA);
      txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
      bus.req_addr = 32'h40; bus.req_wdata = 32'h12345678;
      n = 0;
      while (!bus.req_ready && n < MAXW) begin @(negedge clk); n++; end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
        n_fail++; $display("FAIL reset_in_wait outputs: valid=%0b ready=%0b rdata=%h err=%0b want 0/1/0/0",
                           bus.resp_valid, bus.req_ready, bus.resp_rdata, bus.resp_err);
      end
      n_checks++;
      @(negedge clk);
      rst_n = 1'b1;
      saw_resp = 1'b0;
      for (int i = 0; i < LAT + 4; i++) begin
        @(negedge clk);
        if (bus.resp_valid) saw_resp = 1'b1;
      end
      if (saw_resp !== 1'b0) begin n_fail++; $display("FAIL reset_in_wait response: got pulse want none"); end
      n_checks++;
      txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      if (obs_rd !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL reset_in_wait store_dropped: got %h want aaaaaaaa", obs_rd); end
      n_checks++;
    end
  endtask

  task automatic test_reset_in_resp();
    int n;
    logic seen;
    model_access(1'b1, 2'd2, 1'b0, 32'h44, 32'h5A5AC3C3);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h44; bus.req_wdata = 32'h5A5AC3C3;
    n = 0;
    while (!bus.req_ready && n < MAXW) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < MAXW; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin seen = 1'b1; break; end
    end
    if (seen !== 1'b1) begin n_fail++; $display("FAIL reset_in_resp: no response within %0d cycles", MAXW); end
    n_checks++;
    rst_n = 1'b0;
    #1;
    if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_in_resp valid: got %0b want 0", bus.resp_valid); end
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    if (obs_rd !== 32'h5A5AC3C3) begin n_fail++; $display("FAIL reset_in_resp commit: got %h want 5a5ac3c3", obs_rd); end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int          acc_c [$];
    int          rsp_c [$];
    logic [31:0] rsp_d [$];
    logic [31:0] wd;
    logic        switch_pend;
    wd = $urandom;
    switch_pend = 1'b0;
    model_access(1'b1, 2'd2, 1'b0, 32'h60, wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h60; bus.req_wdata = wd;
    for (int c = 0; c < 2*(LAT + 2) + 6; c++) begin
      if (c > 0) @(negedge clk);
      if (switch_pend) begin
        bus.req_we = 1'b0; bus.req_wdata = ~wd; switch_pend = 1'b0;
      end
      if (bus.resp_valid) begin
        rsp_c.push_back(c);
        rsp_d.push_back(bus.resp_rdata);
        if (rsp_c.size() == 2) bus.req_valid = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_c.push_back(c);
        if (acc_c.size() == 1) switch_pend = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    model_access(1'b0, 2'd2, 1'b0, 32'h60, 32'h0);
    if (acc_c.size() != 2 || rsp_c.size() != 2) begin
      n_fail++; $display("FAIL b2b counts: accepts=%0d responses=%0d want 2/2", acc_c.size(), rsp_c.size());
    end
    n_checks++;
    if (acc_c.size() == 2 && rsp_c.size() == 2) begin
      if (acc_c[1] - acc_c[0] != LAT + 2) begin
        n_fail++; $display("FAIL b2b spacing: got %0d want %0d", acc_c[1] - acc_c[0], LAT + 2);
      end
      n_checks++;
      if (rsp_c[0] - acc_c[0] != LAT + 1 || rsp_c[1] - acc_c[1] != LAT + 1) begin
        n_fail++; $display("FAIL b2b latency: got %0d/%0d want %0d", rsp_c[0] - acc_c[0], rsp_c[1] - acc_c[1], LAT + 1);
      end
      n_checks++;
      if (rsp_d[1] !== exp_rd) begin n_fail++; $display("FAIL b2b load_after_store: got %h want %h", rsp_d[1], exp_rd); end
      n_checks++;
    end
  endtask

  task automatic test_random();
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          r;
    for (int t = 0; t < 150; t++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      r   = $urandom_range(0, 9);
      sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r   = $urandom_range(0, 7);
      a   = (r == 0) ? 32'(4*DEPTH + $urandom_range(0, 15)) :
            (r == 1) ? 32'(4*DEPTH - 4 + $urandom_range(0, 3)) : 32'($urandom_range(0, 127));
      wd  = $urandom;
      txn(we, sz, uns, a, wd);
      if (obs_seen !== 1'b1 || obs_lat != LAT + 1) begin
        n_fail++; $display("FAIL rand %0d timing: seen=%0b lat=%0d want 1/%0d", t, obs_seen, obs_lat, LAT + 1);
      end
      n_checks++;
      if (obs_err !== exp_err) begin
        n_fail++; $display("FAIL rand %0d err: we=%0b sz=%0d a=%h got %0b want %0b", t, we, sz, a, obs_err, exp_err);
      end
      n_checks++;
      if (obs_rd !== exp_rd) begin
        n_fail++; $display("FAIL rand %0d rdata: we=%0b sz=%0d uns=%0b a=%h got %h want %h", t, we, sz, uns, a, obs_rd, exp_rd);
      end
      n_checks++;
    end
  endtask

`ifdef DMEM_ACCESS_CNT_EN
  task automatic test_counters();
    apply_reset();
    if (rd_count !== 16'd0 || wr_count !== 16'd0 || err_count !== 8'd0) begin
      n_fail++; $display("FAIL counters_reset: rd=%0d wr=%0d err=%0d want 0/0/0", rd_count, wr_count, err_count);
    end
    n_checks++;
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    txn(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);
    txn(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
    txn(1'b1, 2'd2, 1'b0, 32'h48, $urandom);
    txn(1'b1, 2'd0, 1'b0, 32'h4C, $urandom);
    txn(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    if (rd_count !== 16'd3) begin n_fail++; $display("FAIL rd_count: got %0d want 3", rd_count); end
    n_checks++;
    if (wr_count !== 16'd2) begin n_fail++; $display("FAIL wr_count: got %0d want 2", wr_count); end
    n_checks++;
    if (err_count !== 8'd1) begin n_fail++; $display("FAIL err_count: got %0d want 1", err_count); end
    n_checks++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    prime_memory();
    test_word_store_load();
    test_byte_lanes();
    test_errors();
    test_reset_mid_wait();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
`ifdef DMEM_ACCESS_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
